// File: rtl/led_matrix_scan.sv
// Row-multiplexed driver for an 8x8 red/green dot matrix.
// A double-buffered frame is reloaded once per full scan; each row slot starts
// with a blanking gap so the previous row's columns never ghost into the next.
module led_matrix_scan #(
  parameter int unsigned ROW_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES = 50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [127:0] matrixData,
  output logic [7:0]   row_n,
  output logic [7:0]   col_r,
  output logic [7:0]   col_g,
  output logic         frame_sync
);

  localparam int unsigned DivW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(ROW_CYCLES - 1);
  localparam logic [DivW-1:0] DivBlank = DivW'(BLANK_CYCLES);

  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      row_idx_q, row_idx_d;
  logic [127:0]    fbuf_q, fbuf_d;
  logic            row_end, load, blank;

  // Per-row view of the frame buffer: element r holds the 16 bits of row r.
  logic [7:0][15:0] fbuf_rows;
  logic [15:0]      row_bits;

  logic [7:0] row_n_d, col_r_d, col_g_d;

  assign fbuf_rows = fbuf_q;
  assign row_bits  = fbuf_rows[row_idx_q];

  // Slot/row counters and frame-buffer load at the very end of row 7.
  always_comb begin
    row_end   = (div_q == DivLast);
    load      = en && row_end && (row_idx_q == 3'd7);
    div_d     = div_q;
    row_idx_d = row_idx_q;
    if (!en) begin
      div_d     = '0;
      row_idx_d = '0;
    end else if (row_end) begin
      div_d     = '0;
      row_idx_d = row_idx_q + 3'd1;
    end else begin
      div_d = div_q + DivW'(1);
    end
    fbuf_d = load ? matrixData : fbuf_q;
  end

  // Output decode from the pre-edge counters; dark during blanking or when disabled.
  always_comb begin
    blank   = !en || (div_q < DivBlank);
    row_n_d = 8'hFF;
    col_r_d = 8'h00;
    col_g_d = 8'h00;
    if (!blank) begin
      row_n_d = ~(8'd1 << row_idx_q);
      for (int c = 0; c < 8; c++) begin
        col_r_d[c] = row_bits[2*c+1];
        col_g_d[c] = row_bits[2*c];
      end
    end
  end

  // State and registered outputs; reset blanks the panel without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      row_idx_q  <= '0;
      fbuf_q     <= '0;
      row_n      <= 8'hFF;
      col_r      <= 8'h00;
      col_g      <= 8'h00;
      frame_sync <= 1'b0;
    end else begin
      div_q      <= div_d;
      row_idx_q  <= row_idx_d;
      fbuf_q     <= fbuf_d;
      row_n      <= row_n_d;
      col_r      <= col_r_d;
      col_g      <= col_g_d;
      frame_sync <= load;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan with short row slots.
// A scan-position model predicts every output each cycle; literal checks pin the model.
module tb_led_matrix_scan;

  localparam int RC = 10;
  localparam int BC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [127:0] md;
  logic [7:0]   row_n, col_r, col_g;
  logic         frame_sync;

  int vectors    = 0;
  int miscompares = 0;

  // Model state: position within the scan since reset / enable, plus displayed frame.
  int           pos;
  logic [127:0] m_fbuf;
  logic [7:0]   e_row, e_r, e_g;
  logic         e_sync;

  led_matrix_scan #(
    .ROW_CYCLES  (RC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .matrixData(md),
    .row_n     (row_n),
    .col_r     (col_r),
    .col_g     (col_g),
    .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict this edge from pre-edge inputs, clock once, then compare everything.
  task automatic tick();
    int r;
    e_row = 8'hFF;
    e_r   = 8'h00;
    e_g   = 8'h00;
    if (en && (pos % RC) >= BC) begin
      r     = (pos / RC) % 8;
      e_row = ~(8'd1 << r);
      for (int c = 0; c < 8; c++) begin
        e_r[c] = m_fbuf[2*(8*r+c)+1];
        e_g[c] = m_fbuf[2*(8*r+c)];
      end
    end
    e_sync = en && ((pos % (8*RC)) == 8*RC-1);
    if (e_sync) m_fbuf = md;
    pos = en ? pos + 1 : 0;
    @(posedge clk);
    #1;
    chk("model row_n", row_n, e_row);
    chk("model col_r", col_r, e_r);
    chk("model col_g", col_g, e_g);
    chk("model frame_sync", {7'd0, frame_sync}, {7'd0, e_sync});
    chk("one-row invariant", {7'd0, ($countones(~row_n) <= 1)}, 8'd1);
    chk("dark-cols invariant", {7'd0, (row_n != 8'hFF) || ((col_r | col_g) == 8'h00)}, 8'd1);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    md     = '0;
    pos    = 0;
    m_fbuf = '0;
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset row_n", row_n, 8'hFF);
    chk("reset col_r", col_r, 8'h00);
    chk("reset col_g", col_g, 8'h00);
    chk("reset frame_sync", {7'd0, frame_sync}, 8'd0);

    // First scan shows the zeroed buffer; red frame appears on the second scan.
    md  = {64{2'b10}};
    en  = 1'b1;
    rst = 1'b0;
    tick_n(79);
    chk("no sync at 79", {7'd0, frame_sync}, 8'd0);
    tick_n(1);
    chk("sync at 80", {7'd0, frame_sync}, 8'd1);
    tick_n(3);
    chk("c83 row_n", row_n, 8'hFE);
    chk("c83 col_r", col_r, 8'hFF);
    chk("c83 col_g", col_g, 8'h00);
    tick_n(7);
    chk("c90 row_n", row_n, 8'hFE);
    tick_n(1);
    chk("c91 blank row_n", row_n, 8'hFF);
    chk("c91 blank col_r", col_r, 8'h00);
    tick_n(2);
    chk("c93 row_n", row_n, 8'hFD);
    chk("c93 col_r", col_r, 8'hFF);

    // Single green pixel at row 2, column 3; loads at cycle 160.
    md = 128'd1 << 38;
    tick_n(67);
    chk("sync at 160", {7'd0, frame_sync}, 8'd1);
    tick_n(15);
    chk("pixel row1 row_n", row_n, 8'hFD);
    chk("pixel row1 col_g", col_g, 8'h00);
    tick_n(10);
    chk("pixel row2 row_n", row_n, 8'hFB);
    chk("pixel row2 col_g", col_g, 8'h08);
    chk("pixel row2 col_r", col_r, 8'h00);

    // Yellow arrives mid-row-3; current scan must keep the old frame.
    tick_n(10);
    md = {64{2'b11}};
    tick_n(2);
    chk("old frame row3 row_n", row_n, 8'hF7);
    chk("old frame row3 col_g", col_g, 8'h00);
    tick_n(38);
    chk("old frame row7 row_n", row_n, 8'h7F);
    chk("old frame row7 col_r", col_r, 8'h00);
    tick_n(8);
    chk("yellow row0 row_n", row_n, 8'hFE);
    chk("yellow row0 col_r", col_r, 8'hFF);
    chk("yellow row0 col_g", col_g, 8'hFF);

    // Drop enable at row 5, div 6 for 20 edges, then restart from row 0.
    tick_n(53);
    en = 1'b0;
    tick();
    chk("en low row_n", row_n, 8'hFF);
    chk("en low sync", {7'd0, frame_sync}, 8'd0);
    tick_n(19);
    en = 1'b1;
    tick_n(2);
    chk("restart blank row_n", row_n, 8'hFF);
    tick();
    chk("restart row0 row_n", row_n, 8'hFE);
    chk("retained col_r", col_r, 8'hFF);
    chk("retained col_g", col_g, 8'hFF);

    // Asynchronous reset while a row is lit.
    tick_n(2);
    #1 rst = 1'b1;
    #1;
    chk("async rst row_n", row_n, 8'hFF);
    chk("async rst col_r", col_r, 8'h00);
    chk("async rst col_g", col_g, 8'h00);
    pos    = 0;
    m_fbuf = '0;
    @(negedge clk);
    rst = 1'b0;
    tick_n(3);
    chk("post-rst row0 row_n", row_n, 8'hFE);
    chk("post-rst dark col_r", col_r, 8'h00);
    chk("post-rst dark col_g", col_g, 8'h00);
    tick_n(77);
    chk("post-rst sync", {7'd0, frame_sync}, 8'd1);
    tick_n(3);
    chk("post-rst reload col_r", col_r, 8'hFF);

    // Random frames with enable toggling; model and invariants checked every cycle.
    for (int i = 0; i < 10000; i++) begin
      md = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 39) == 0) en = ~en;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
